// File: rtl/bus_xfer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl_pkg
//   Shared definitions for the CTI-8 bus transfer controller: default bus
//   geometry, the transaction FSM state type and an index range helper.
// -----------------------------------------------------------------------------
package bus_xfer_ctrl_pkg;

  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_DATA_W   = 8;

  // Transaction phases, in the order a normal transfer walks through them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  // True when a register index addresses an existing slave.
  function automatic logic idx_ok(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_bus_sel_decoder.sv
// -----------------------------------------------------------------------------
// bus_sel_decoder
//   Turns a register index plus an enable into a one-hot (or all-zero) select
//   vector. Used once for the oe strobes and once for the wr strobes.
// Ports
//   idx  in   IDX_W  register index
//   en   in   1      when 0 the output is all zeros
//   sel  out  N      one-hot select; zero for out-of-range indices
// -----------------------------------------------------------------------------
module bus_sel_decoder #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     sel
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel = '0;
    if (en && (32'(idx) < N)) begin
      sel[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
//   Initiator of the shared CTI-8 tri-state data bus. Runs each register move,
//   immediate load or bus read as a fixed three-cycle transaction (drive,
//   write, turnaround) by pulsing per-register oe/wr strobes, so two drivers
//   never overlap on the bus.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE and out of reset)
//   req_src/dst         source / destination register indices
//   req_dst_en          1 = write the destination, 0 = capture only
//   req_imm_en, req_imm drive req_imm onto the bus instead of a register
//   oe, wr              registered one-hot output enables / write strobes
//   dataBus             shared bus; driven here only for immediates
//   done, done_err      end-of-transaction pulse and rejection flag
//   xfer_data           bus value sampled on the write edge
// -----------------------------------------------------------------------------
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_src,
  input  logic [IDX_W-1:0]  req_dst,
  input  logic              req_dst_en,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] wr,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              done,
  output logic              done_err,
  output logic [DATA_W-1:0] xfer_data
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    src_q, src_d, dst_q, dst_d;
  logic                dst_en_q, dst_en_d, imm_en_q, imm_en_d, err_q, err_d;
  logic [DATA_W-1:0]   imm_q, imm_d;

  logic [NUM_REGS-1:0] oe_q, oe_d, wr_q, wr_d;
  logic                drive_q, drive_d;
  logic                done_q, done_d, done_err_q, done_err_d;
  logic [DATA_W-1:0]   xfer_q, xfer_d;

  logic accept, req_err, src_phase, oe_en, wr_en;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Rejected: a register source that does not exist, a destination that does
  // not exist, or a register copied onto itself.
  assign req_err = (!req_imm_en && !idx_ok(32'(req_src), NUM_REGS))
                || (req_dst_en && !idx_ok(32'(req_dst), NUM_REGS))
                || (!req_imm_en && req_dst_en && (req_src == req_dst));

  // Bus outputs are registered from the current state, so each phase shows on
  // the pins one cycle after the FSM enters it: oe spans the DRIVE and WRITE
  // phases, wr the WRITE phase, done the TURN phase.
  assign src_phase = (state_q == ST_DRIVE) || (state_q == ST_WRITE);
  assign oe_en     = src_phase && !imm_en_q;
  assign wr_en     = (state_q == ST_WRITE) && dst_en_q;

  bus_sel_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_oe_dec (
    .idx (src_q),
    .en  (oe_en),
    .sel (oe_d)
  );

  bus_sel_decoder #(.N(NUM_REGS), .IDX_W(IDX_W)) u_wr_dec (
    .idx (dst_q),
    .en  (wr_en),
    .sel (wr_d)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    dst_en_d = dst_en_q;
    imm_en_d = imm_en_q;
    imm_d    = imm_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d    = req_src;
          dst_d    = req_dst;
          dst_en_d = req_dst_en;
          imm_en_d = req_imm_en;
          imm_d    = req_imm;
          err_d    = req_err;
          // Rejected requests skip straight to the done pulse.
          state_d  = req_err ? ST_TURN : ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_TURN;
      ST_TURN:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drive_d    = src_phase && imm_en_q;
    done_d     = (state_q == ST_TURN);
    done_err_d = (state_q == ST_TURN) && err_q;
    // The TURN-state edge is the one on which the slave latches wr, so the
    // bus is sampled here while the source is still driving.
    xfer_d     = ((state_q == ST_TURN) && !err_q) ? dataBus : xfer_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      oe_q       <= '0;
      wr_q       <= '0;
      drive_q    <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      wr_q       <= wr_d;
      drive_q    <= drive_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      xfer_q     <= xfer_d;
    end
  end

  // NOTE: the request latch carries no reset; it is only read after an accept has loaded it.
  always_ff @(posedge clk) begin
    src_q    <= src_d;
    dst_q    <= dst_d;
    dst_en_q <= dst_en_d;
    imm_en_q <= imm_en_d;
    imm_q    <= imm_d;
    err_q    <= err_d;
  end

  assign dataBus   = drive_q ? imm_q : {DATA_W{1'bz}};
  assign oe        = oe_q;
  assign wr        = wr_q;
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign xfer_data = xfer_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
//   Self-checking bench: eight register slaves share the tri-state bus with
//   the controller. A vector table covers immediate loads, moves, read-only
//   captures and rejected requests; hand-written sequences cover back-to-back
//   requests and reset during a transaction.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

  localparam int NR = 8;
  localparam int DW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_dst_en, req_imm_en;
  logic [IW-1:0] req_src, req_dst;
  logic [DW-1:0] req_imm;
  logic          req_ready, done, done_err;
  logic [NR-1:0] oe, wr;
  logic [DW-1:0] xfer_data;
  wire  [DW-1:0] data_bus;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_dst_en (req_dst_en),
    .req_imm_en (req_imm_en),
    .req_imm    (req_imm),
    .oe         (oe),
    .wr         (wr),
    .dataBus    (data_bus),
    .done       (done),
    .done_err   (done_err),
    .xfer_data  (xfer_data)
  );

  // ---------------- register slaves ----------------
  logic [DW-1:0] regs [NR] = '{default: '0};
  logic [DW-1:0] slave_val;
  logic          slave_en;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) if (wr[i]) regs[i] <= data_bus;
  end

  always_comb begin
    slave_en  = 1'b0;
    slave_val = '0;
    for (int i = 0; i < NR; i++) begin
      if (oe[i]) begin
        slave_en  = 1'b1;
        slave_val = regs[i];
      end
    end
  end

  assign data_bus = slave_en ? slave_val : {DW{1'bz}};

  // ---------------- activity monitor ----------------
  int cyc = 0;
  int oe_any = 0, wr_any = 0, multi_hot = 0, done_seen = 0;
  int oe_bits [NR] = '{default: 0};
  int wr_bits [NR] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oe != '0) oe_any <= oe_any + 1;
    if (wr != '0) wr_any <= wr_any + 1;
    if ($countones(oe) > 1 || $countones(wr) > 1) multi_hot <= multi_hot + 1;
    if (done) done_seen <= done_seen + 1;
    for (int i = 0; i < NR; i++) begin
      oe_bits[i] <= oe_bits[i] + int'(oe[i]);
      wr_bits[i] <= wr_bits[i] + int'(wr[i]);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          imm_en;
    logic [DW-1:0] imm;
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic          dst_en;
    logic [DW-1:0] exp_xfer;
    logic          exp_err;
    int            exp_oe;
    int            exp_wr;
    logic [IW-1:0] chk_idx;
    logic [DW-1:0] chk_val;
  } vec_t;

  vec_t vecs [8];

  task automatic set_req(input logic imm_en, input logic [DW-1:0] imm,
                         input logic [IW-1:0] src, input logic [IW-1:0] dst,
                         input logic dst_en);
    req_imm_en = imm_en;
    req_imm    = imm;
    req_src    = src;
    req_dst    = dst;
    req_dst_en = dst_en;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int s_oe_any, s_wr_any, s_oe_bit, s_wr_bit, s_done, lat, n;
    @(negedge clk);
    set_req(v.imm_en, v.imm, v.src, v.dst, v.dst_en);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready", k), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    s_oe_any = oe_any;
    s_wr_any = wr_any;
    s_oe_bit = oe_bits[v.src];
    s_wr_bit = wr_bits[v.dst];
    s_done   = done_seen;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    // Normal: accept at N, done during N+3..N+4 (4th falling edge); rejected: 2nd.
    check($sformatf("v%0d_done_latency", k), 32'(lat), v.exp_err ? 32'd2 : 32'd4);
    check($sformatf("v%0d_done_err", k), 32'(done_err), 32'(v.exp_err));
    check($sformatf("v%0d_xfer_data", k), 32'(xfer_data), 32'(v.exp_xfer));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse_end", k), 32'(done), 32'd0);
    check($sformatf("v%0d_oe_idle", k), 32'(oe), 32'd0);
    check($sformatf("v%0d_wr_idle", k), 32'(wr), 32'd0);
    check($sformatf("v%0d_ready_after", k), 32'(req_ready), 32'd1);
    #1;
    check($sformatf("v%0d_oe_cycles", k), 32'(oe_any - s_oe_any), 32'(v.exp_oe));
    check($sformatf("v%0d_oe_src_cycles", k), 32'(oe_bits[v.src] - s_oe_bit), 32'(v.exp_oe));
    check($sformatf("v%0d_wr_cycles", k), 32'(wr_any - s_wr_any), 32'(v.exp_wr));
    check($sformatf("v%0d_wr_dst_cycles", k), 32'(wr_bits[v.dst] - s_wr_bit), 32'(v.exp_wr));
    check($sformatf("v%0d_done_count", k), 32'(done_seen - s_done), 32'd1);
    check($sformatf("v%0d_reg%0d", k, v.chk_idx), 32'(regs[v.chk_idx]), 32'(v.chk_val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [3];
    int s_done, s_oe, n;
    logic [IW-1:0] bb_src [3];
    logic [IW-1:0] bb_dst [3];

    //            imm  imm    src   dst   den   xfer   err  oe wr  chk   val
    vecs[0] = '{1'b1, 8'h42, 3'd0, 3'd3, 1'b1, 8'h42, 1'b0, 0, 1, 3'd3, 8'h42};
    vecs[1] = '{1'b1, 8'hAA, 3'd0, 3'd1, 1'b1, 8'hAA, 1'b0, 0, 1, 3'd1, 8'hAA};
    vecs[2] = '{1'b0, 8'h00, 3'd1, 3'd5, 1'b1, 8'hAA, 1'b0, 2, 1, 3'd5, 8'hAA};
    vecs[3] = '{1'b0, 8'h00, 3'd5, 3'd0, 1'b0, 8'hAA, 1'b0, 2, 0, 3'd0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 3'd2, 3'd2, 1'b1, 8'hAA, 1'b1, 0, 0, 3'd2, 8'h00};
    vecs[5] = '{1'b1, 8'h5A, 3'd0, 3'd2, 1'b1, 8'h5A, 1'b0, 0, 1, 3'd2, 8'h5A};
    vecs[6] = '{1'b1, 8'h77, 3'd0, 3'd4, 1'b0, 8'h77, 1'b0, 0, 0, 3'd4, 8'h00};
    vecs[7] = '{1'b0, 8'h00, 3'd2, 3'd7, 1'b1, 8'h5A, 1'b0, 2, 1, 3'd7, 8'h5A};

    rst       = 1'b1;
    req_valid = 1'b0;
    set_req(1'b0, 8'h00, 3'd0, 3'd0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_err", 32'(done_err), 32'd0);
    check("rst_xfer_data", 32'(xfer_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Table-driven transfers
    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);
    check("reg1_unchanged_by_move", 32'(regs[1]), 32'h000000AA);

    // Back-to-back: R3->R0, R5->R6, R0->R4 with req_valid held high
    bb_src = '{3'd3, 3'd5, 3'd0};
    bb_dst = '{3'd0, 3'd6, 3'd4};
    s_done = done_seen;
    @(negedge clk);
    set_req(1'b0, 8'h00, bb_src[0], bb_dst[0], 1'b1);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 12) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      acc[k] = cyc;
      if (k < 2) set_req(1'b0, 8'h00, bb_src[k+1], bb_dst[k+1], 1'b1);
      else       req_valid = 1'b0;
    end
    check("b2b_gap_01", 32'(acc[1] - acc[0]), 32'd4);
    check("b2b_gap_12", 32'(acc[2] - acc[1]), 32'd4);
    repeat (6) @(negedge clk);
    #1;
    check("b2b_done_count", 32'(done_seen - s_done), 32'd3);
    check("b2b_reg0", 32'(regs[0]), 32'h00000042);
    check("b2b_reg6", 32'(regs[6]), 32'h000000AA);
    check("b2b_reg4", 32'(regs[4]), 32'h00000042);

    // Reset one cycle after accepting R1->R2 (R2 holds 0x5A)
    @(negedge clk);
    set_req(1'b0, 8'h00, 3'd1, 3'd2, 1'b1);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    s_done = done_seen;
    s_oe   = oe_any;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", 32'(oe), 32'd0);
    check("mid_rst_wr", 32'(wr), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_seen - s_done), 32'd0);
    check("mid_rst_no_oe", 32'(oe_any - s_oe), 32'd0);
    check("mid_rst_dst_kept", 32'(regs[2]), 32'h0000005A);

    check("no_multi_hot", 32'(multi_hot), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
